// File: rtl/vx_gbar_hub_if.sv
// Socket-side barrier request bus plus release/error status of the global barrier hub.
interface vx_gbar_hub_if #(
  parameter int NUM_REQS = 4,
  parameter int BAR_W    = 3,
  parameter int CID_W    = 4
);
  logic [NUM_REQS-1:0]       req_valid;
  logic [NUM_REQS*BAR_W-1:0] req_id;
  logic [NUM_REQS*CID_W-1:0] req_size_m1;
  logic [NUM_REQS*CID_W-1:0] req_core_id;
  logic [NUM_REQS-1:0]       req_ready;
  logic                      rsp_valid;
  logic [BAR_W-1:0]          rsp_id;
  logic                      err_valid;
  logic [1:0]                err_code;
  logic [BAR_W-1:0]          err_id;
  logic                      busy;

  modport master (
    output req_valid, req_id, req_size_m1, req_core_id,
    input  req_ready, rsp_valid, rsp_id, err_valid, err_code, err_id, busy
  );

  modport slave (
    input  req_valid, req_id, req_size_m1, req_core_id,
    output req_ready, rsp_valid, rsp_id, err_valid, err_code, err_id, busy
  );
endinterface

// File: rtl/vx_gbar_hub.sv
// Cluster global barrier hub: round-robin merge of socket requests, per-id arrival tracking.
// state      | meaning
// ST_IDLE    | barrier id has no pending arrivals (cnt == 0)
// ST_FILLING | barrier id has collected some, but not all, arrivals
module vx_gbar_hub #(
  parameter int NUM_REQS     = 4,
  parameter int NUM_BARRIERS = 8,
  parameter int NUM_CORES    = 16
) (
  input logic          clk,
  input logic          reset,
  vx_gbar_hub_if.slave bus
);
  localparam int BAR_W = $clog2(NUM_BARRIERS);
  localparam int CID_W = $clog2(NUM_CORES);
  localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_FILLING = 1'b1} bar_state_e;

  logic [PTR_W-1:0]     ptr;
  logic [NUM_REQS-1:0]  grant;
  logic [PTR_W-1:0]     gidx;
  logic                 found;
  logic [BAR_W-1:0]     sel_id;
  logic [CID_W-1:0]     sel_size;
  logic [CID_W-1:0]     sel_core;

  logic [CID_W:0]       cnt    [NUM_BARRIERS];
  logic [CID_W:0]       cnt_n  [NUM_BARRIERS];
  logic [CID_W-1:0]     size_q [NUM_BARRIERS];
  logic [CID_W-1:0]     size_n [NUM_BARRIERS];
  logic [NUM_CORES-1:0] mask_q [NUM_BARRIERS];
  logic [NUM_CORES-1:0] mask_n [NUM_BARRIERS];

  bar_state_e           st_sel;
  logic                 rel_n;
  logic [BAR_W-1:0]     rel_id_n;
  logic                 err_n;
  logic [1:0]           err_code_n;
  logic                 any_pending;

  always_comb begin
    int idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (int'(ptr) + k) % NUM_REQS;
      if (!found && bus.req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PTR_W'(idx);
      end
    end
  end

  assign bus.req_ready = grant;
  assign sel_id   = bus.req_id[gidx*BAR_W +: BAR_W];
  assign sel_size = bus.req_size_m1[gidx*CID_W +: CID_W];
  assign sel_core = bus.req_core_id[gidx*CID_W +: CID_W];

  always_comb begin
    cnt_n      = cnt;
    size_n     = size_q;
    mask_n     = mask_q;
    rel_n      = 1'b0;
    rel_id_n   = '0;
    err_n      = 1'b0;
    err_code_n = 2'b00;
    st_sel     = (cnt[sel_id] == '0) ? ST_IDLE : ST_FILLING;
    if (found) begin
      unique case (st_sel)
        ST_IDLE: begin
          size_n[sel_id] = sel_size;
          mask_n[sel_id] = NUM_CORES'(1) << sel_core;
          if (sel_size == '0) begin
            rel_n    = 1'b1;
            rel_id_n = sel_id;
          end else begin
            cnt_n[sel_id] = (CID_W+1)'(1);
          end
        end
        ST_FILLING: begin
          // A repeated core is dropped entirely so it cannot complete the barrier early.
          if (mask_q[sel_id][sel_core]) begin
            err_n      = 1'b1;
            err_code_n = 2'b10;
          end else begin
            if (sel_size != size_q[sel_id]) begin
              err_n      = 1'b1;
              err_code_n = 2'b01;
            end
            if (cnt[sel_id] == {1'b0, size_q[sel_id]}) begin
              rel_n          = 1'b1;
              rel_id_n       = sel_id;
              cnt_n[sel_id]  = '0;
              mask_n[sel_id] = '0;
            end else begin
              cnt_n[sel_id]            = cnt[sel_id] + 1'b1;
              mask_n[sel_id][sel_core] = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    any_pending = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (cnt[b] != '0) any_pending = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.err_valid <= 1'b0;
      bus.err_code  <= 2'b00;
      bus.err_id    <= '0;
      bus.busy      <= 1'b0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        cnt[b]    <= '0;
        size_q[b] <= '0;
        mask_q[b] <= '0;
      end
    end else begin
      if (found) ptr <= (gidx == PTR_W'(NUM_REQS-1)) ? '0 : gidx + 1'b1;
      cnt           <= cnt_n;
      size_q        <= size_n;
      mask_q        <= mask_n;
      bus.rsp_valid <= rel_n;
      bus.rsp_id    <= rel_id_n;
      bus.busy      <= any_pending;
      if (err_n && !bus.err_valid) begin
        bus.err_valid <= 1'b1;
        bus.err_code  <= err_code_n;
        bus.err_id    <= sel_id;
      end
    end
  end
endmodule

// File: tb/tb_vx_gbar_hub.sv
// Directed bench for vx_gbar_hub; an arrival-set model predicts every output each cycle.
module tb_vx_gbar_hub;
  localparam int NR = 4;
  localparam int NB = 8;
  localparam int NC = 16;
  localparam int BW = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  vx_gbar_hub_if #(.NUM_REQS(NR), .BAR_W(BW), .CID_W(CW)) bus();

  vx_gbar_hub #(.NUM_REQS(NR), .NUM_BARRIERS(NB), .NUM_CORES(NC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: set of arrived cores per barrier, captured size, RR pointer, expected outputs.
  bit [NC-1:0] m_seen [NB];
  int          m_size [NB];
  int          m_ptr = 0;
  bit          m_live = 0;
  bit          e_rsp_v = 0;
  int          e_rsp_id = 0;
  bit          e_busy = 0;
  bit          e_err_v = 0;
  int          e_err_code = 0;
  int          e_err_id = 0;

  always @(negedge clk) begin
    int g;
    int b;
    int c;
    int s;
    bit nb;
    bit nrsp;
    int nid;
    logic [NR-1:0] eg;
    g  = -1;
    eg = '0;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (m_ptr + k) % NR;
      if (g < 0 && bus.req_valid[idx] === 1'b1) begin
        g = idx;
        eg[idx] = 1'b1;
      end
    end
    if (m_live) begin
      check("req_ready", bus.req_ready, eg);
      check("rsp_valid", bus.rsp_valid, e_rsp_v);
      if (e_rsp_v) check("rsp_id", bus.rsp_id, e_rsp_id);
      check("busy", bus.busy, e_busy);
      check("err_valid", bus.err_valid, e_err_v);
      if (e_err_v) begin
        check("err_code", bus.err_code, e_err_code);
        check("err_id", bus.err_id, e_err_id);
      end
    end
    nb = 1'b0;
    for (int i = 0; i < NB; i++) if (m_seen[i] != 0) nb = 1'b1;
    nrsp = 1'b0;
    nid  = 0;
    if (reset !== 1'b1 && g >= 0) begin
      b = int'(bus.req_id[g*BW +: BW]);
      s = int'(bus.req_size_m1[g*CW +: CW]);
      c = int'(bus.req_core_id[g*CW +: CW]);
      m_ptr = (g + 1) % NR;
      if (m_seen[b] == 0) begin
        m_size[b] = s;
        if (s == 0) begin
          nrsp = 1'b1;
          nid  = b;
        end else begin
          m_seen[b][c] = 1'b1;
        end
      end else if (m_seen[b][c]) begin
        if (!e_err_v) begin e_err_v = 1; e_err_code = 2; e_err_id = b; end
      end else begin
        if (s != m_size[b] && !e_err_v) begin e_err_v = 1; e_err_code = 1; e_err_id = b; end
        m_seen[b][c] = 1'b1;
        if ($countones(m_seen[b]) == m_size[b] + 1) begin
          nrsp = 1'b1;
          nid  = b;
          m_seen[b] = '0;
        end
      end
    end
    e_rsp_v  = nrsp;
    e_rsp_id = nid;
    e_busy   = nb;
    if (reset === 1'b1) begin
      for (int i = 0; i < NB; i++) begin m_seen[i] = '0; m_size[i] = 0; end
      m_ptr = 0; e_rsp_v = 0; e_rsp_id = 0; e_busy = 0;
      e_err_v = 0; e_err_code = 0; e_err_id = 0;
      m_live = 1;
    end
  end

  task automatic set_req(input int p, input int id, input int sz, input int core);
    bus.req_valid[p]            = 1'b1;
    bus.req_id[p*BW +: BW]      = BW'(id);
    bus.req_size_m1[p*CW +: CW] = CW'(sz);
    bus.req_core_id[p*CW +: CW] = CW'(core);
  endtask

  task automatic wait_grant(input int p);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready[p] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL grant_timeout port=%0d actual=0 required=1", p);
    end
    @(posedge clk);
    #1;
    bus.req_valid[p] = 1'b0;
  endtask

  task automatic arrive(input int p, input int id, input int sz, input int core);
    set_req(p, id, sz, core);
    wait_grant(p);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int ports [5] = '{1, 2, 3, 0, 2};
    int ids   [5] = '{5, 2, 5, 2, 5};
    int szs   [5] = '{2, 1, 2, 1, 2};
    int cores [5] = '{2, 0, 3, 1, 4};
    bus.req_valid = '0;
    bus.req_id = '0;
    bus.req_size_m1 = '0;
    bus.req_core_id = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_err_valid", bus.err_valid, 0);

    // single-core barrier releases immediately
    arrive(0, 3, 0, 5);
    check("t1_rsp_valid", bus.rsp_valid, 1);
    check("t1_rsp_id", bus.rsp_id, 3);
    @(posedge clk); #1;
    check("t1_rsp_pulse", bus.rsp_valid, 0);
    check("t1_busy", bus.busy, 0);

    // four ports contend for the same barrier
    do_reset();
    for (int p = 0; p < NR; p++) set_req(p, 1, 3, p);
    for (int p = 0; p < NR; p++) begin
      wait_grant(p);
      if (p < NR-1) check("t2_no_early_rsp", bus.rsp_valid, 0);
    end
    check("t2_rsp_valid", bus.rsp_valid, 1);
    check("t2_rsp_id", bus.rsp_id, 1);
    @(posedge clk); #1;

    // interleaved barriers
    for (int i = 0; i < 5; i++) begin
      arrive(ports[i], ids[i], szs[i], cores[i]);
      if (i == 3) check("t3_rsp_id2", bus.rsp_id, 2);
    end
    check("t3_rsp_id5", bus.rsp_id, 5);
    check("t3_busy_lag", bus.busy, 1);
    @(posedge clk); #1;
    check("t3_busy_drop", bus.busy, 0);

    // duplicate core
    arrive(0, 0, 1, 7);
    arrive(1, 0, 1, 7);
    check("t4_err_valid", bus.err_valid, 1);
    check("t4_err_code", bus.err_code, 2);
    check("t4_err_id", bus.err_id, 0);
    check("t4_no_rsp", bus.rsp_valid, 0);
    arrive(2, 0, 1, 8);
    check("t4_rsp_id", bus.rsp_id, 0);
    @(posedge clk); #1;

    // size mismatch still counts
    do_reset();
    arrive(0, 4, 1, 1);
    arrive(1, 4, 2, 2);
    check("t5_rsp_valid", bus.rsp_valid, 1);
    check("t5_rsp_id", bus.rsp_id, 4);
    check("t5_err_code", bus.err_code, 1);
    check("t5_err_id", bus.err_id, 4);
    @(posedge clk); #1;

    // reset discards a partial epoch
    do_reset();
    arrive(0, 6, 3, 0);
    arrive(1, 6, 3, 1);
    do_reset();
    check("t6_busy", bus.busy, 0);
    check("t6_err_valid", bus.err_valid, 0);
    check("t6_rsp_valid", bus.rsp_valid, 0);
    for (int i = 0; i < 4; i++) arrive(i, 6, 3, i);
    check("t6_rsp_id", bus.rsp_id, 6);
    @(posedge clk); #1;

    // pointer wrap: after port 2 wins, port 3 beats port 0
    do_reset();
    arrive(2, 3, 2, 0);
    set_req(0, 3, 2, 1);
    set_req(3, 3, 2, 2);
    wait_grant(3);
    check("t7_ready_after_wrap", bus.req_ready, 4'b0001);
    wait_grant(0);
    check("t7_rsp_id", bus.rsp_id, 3);
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
